player_ctrl: RTL

// - Player-side producer for the game FSM: turns button presses into lane, jump and died.
// - Runs per-frame jump physics and collision checks against the obstacle generator.
// - Consumes playing/reset_game from the game FSM; sits between the input synchronizers and the FSM/renderer.

---
 rtl/player_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/player_ctrl.sv
// Player-side controller: button edges -> lane moves, jump physics per frame, sticky collision flag.
// Define DEBOUNCE_EN to put a DEBOUNCE_CYCLES counter debouncer on each button before edge detection.
module player_ctrl #(
   parameter int H_W             = 8,
   parameter int JUMP_V          = 12,
   parameter int GRAVITY         = 1,
   parameter int CLEAR_H         = 16,
   parameter int DEBOUNCE_CYCLES = 65000
) (
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic           pulse,
   input  logic           btn_left,
   input  logic           btn_right,
   input  logic           btn_up,
   input  logic           playing,
   input  logic           reset_game,
   input  logic           obs_at_player,
   input  logic [1:0]     obs_lane,
   input  logic           obs_jumpable,
   output logic [1:0]     lane,
   output logic           jump,
   output logic [H_W-1:0] height,
   output logic           died
);

   typedef enum logic {S_GROUND, S_AIR} jump_state_t;

   localparam logic signed [H_W-1:0] L_JUMP_V  = H_W'(JUMP_V);
   localparam logic signed [H_W-1:0] L_GRAVITY = H_W'(GRAVITY);
   localparam logic [H_W-1:0]        L_CLEAR_H = H_W'(CLEAR_H);

   jump_state_t            r_state;
   logic [1:0]             r_lane;
   logic [H_W-1:0]         r_height;
   logic signed [H_W-1:0]  r_vel;
   logic                   r_died;
   logic [2:0]             r_btn_prev;

   logic [2:0]             w_btn_raw;
   logic [2:0]             w_btn_lvl;
   logic [2:0]             w_btn_edge;
   logic                   w_edge_l;
   logic                   w_edge_r;
   logic                   w_edge_up;
   logic signed [H_W:0]    w_nxt;
   logic                   w_land;
   logic                   w_hit;

   // Bit order: 0 = left, 1 = right, 2 = up.
   assign w_btn_raw = {btn_up, btn_right, btn_left};

`ifdef DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_db
         logic [DB_W-1:0] r_cnt;
         logic            r_lvl;

         // Any cycle matching the current level restarts the stability count.
         always_ff @(posedge clk_in) begin
            if (!rst_in) begin
               r_cnt <= '0;
               r_lvl <= 1'b0;
            end else if (w_btn_raw[gi] == r_lvl) begin
               r_cnt <= '0;
            end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               r_cnt <= '0;
               r_lvl <= w_btn_raw[gi];
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign w_btn_lvl[gi] = r_lvl;
      end
   endgenerate
`else
   assign w_btn_lvl = w_btn_raw;
`endif

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_btn_prev <= '0;
      end else begin
         r_btn_prev <= w_btn_lvl;
      end
   end

   assign w_btn_edge = w_btn_lvl & ~r_btn_prev;
   assign w_edge_l   = w_btn_edge[0];
   assign w_edge_r   = w_btn_edge[1];
   assign w_edge_up  = w_btn_edge[2];

   // Height is unsigned, velocity signed; one extra bit lets a landing show up as <= 0.
   assign w_nxt  = $signed({1'b0, r_height}) + $signed({r_vel[H_W-1], r_vel});
   assign w_land = w_nxt[H_W] || (w_nxt == '0);

   assign w_hit = obs_at_player && (obs_lane == r_lane) &&
                  !(obs_jumpable && (r_height >= L_CLEAR_H));

   always_ff @(posedge clk_in) begin
      if (!rst_in || reset_game) begin
         r_state  <= S_GROUND;
         r_lane   <= 2'd1;
         r_height <= '0;
         r_vel    <= '0;
         r_died   <= 1'b0;
      end else if (playing) begin
         if (pulse && w_hit) begin
            r_died <= 1'b1;
         end

         if (w_edge_l && !w_edge_r && (r_lane != 2'd0)) begin
            r_lane <= r_lane - 2'd1;
         end else if (w_edge_r && !w_edge_l && (r_lane != 2'd2)) begin
            r_lane <= r_lane + 2'd1;
         end

         case (r_state)
            S_GROUND: begin
               if (w_edge_up) begin
                  r_state <= S_AIR;
                  r_vel   <= L_JUMP_V;
               end
            end
            S_AIR: begin
               if (pulse) begin
                  r_vel <= r_vel - L_GRAVITY;
                  if (w_land) begin
                     r_state  <= S_GROUND;
                     r_height <= '0;
                     r_vel    <= '0;
                  end else begin
                     r_height <= w_nxt[H_W-1:0];
                  end
               end
            end
            default: r_state <= S_GROUND;
         endcase
      end
   end

   assign lane   = r_lane;
   assign height = r_height;
   assign died   = r_died;
   // Outside PLAYING the FSM watches jump for its start/restart handshake.
   assign jump   = playing ? (r_state == S_AIR) : w_btn_lvl[2];

endmodule
